cla32_arbiter: RTL and testbench
================================

Name: cla32_arbiter

Overview:
Shares one 32-bit CLA adder (cla32 instance outside this block) between two requesters. Uses a round-robin grant and a valid/ready operand handshake. Registers operands onto the adder, holds them for a programmable settle time, then captures sum/Cout/overflow into a per-requester result register. Each result register is drained by its own valid/ready handshake. Sits between the ALU-side requesters and the shared adder datapath.

Parameters:
WIDTH, 32, operand/sum width (must match the cla32 instance)
ADD_CYCLES, 1, cycles operands are held on the adder before capture; legal range 1..15

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 operands valid
req0_ready  out  1  requester 0 operands accepted this cycle
req0_a, req0_b  in  WIDTH  requester 0 operands
req0_cin  in  1  requester 0 carry-in
req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as above, requester 1
res0_valid  out  1  result for requester 0 held
res0_ready  in  1  requester 0 consumes result
res0_sum  out  WIDTH  captured sum
res0_cout, res0_ovf  out  1  captured carry-out and signed overflow
res1_valid, res1_ready, res1_sum, res1_cout, res1_ovf  same as above, requester 1
add_a, add_b  out  WIDTH  registered operands to the adder
add_cin  out  1  registered carry-in to the adder
add_sum  in  WIDTH  adder sum
add_cout, add_ovf  in  1  adder carry-out and overflow

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, last_grant=1 (so requester 0 wins the first tie).
  - add_a/add_b/add_cin=0; res*_valid=0; res*_sum/cout/ovf=0.
  - Any in-flight op is discarded. No ready/valid is asserted during the reset cycle.
- Eligibility: eligible_N = reqN_valid && !resN_valid. A requester whose result is still unread is not granted.
- Grant (combinational, IDLE only):
  - If both are eligible, grant the one that is not last_grant.
  - Otherwise grant the single eligible requester; none if neither is eligible.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready per cycle. Ready never asserts outside IDLE.
- FSM states:
  - IDLE: on an edge with reqN_valid && reqN_ready, latch reqN_a/b/cin into add_a/b/cin, set owner=N, last_grant=N, cnt=ADD_CYCLES-1, go to EXEC.
  - EXEC: if cnt!=0, decrement cnt. If cnt==0 at an edge, load res[owner]_sum/cout/ovf from add_sum/add_cout/add_ovf, set res[owner]_valid=1, go to IDLE.
- Latency and throughput:
  - With handshake at edge E, the result is captured at edge E+ADD_CYCLES, and res_valid is visible in the following cycle.
  - Maximum throughput is one op per ADD_CYCLES+1 cycles.
- add_a/b/cin hold their last value in IDLE; they change only on accept.
- Result drain:
  - resN_valid && resN_ready at an edge clears resN_valid; the data fields hold their value.
  - A drain and a capture into the same slot in the same edge cannot happen, because eligibility blocks it.
  - Drain of slot X and capture into slot Y≠X in the same edge are both performed.
- Drain/re-grant timing: in the same cycle a slot drains, its requester is still ineligible. It can be granted on the next IDLE cycle.
- Stable operands: requesters must keep operands stable while valid && !ready. The block samples only at the handshake edge.
- No arithmetic is done locally; sum/flags are the adder's values, unmodified. Sum wraps mod 2^WIDTH.
- rst asserted in EXEC: the operation is lost and no res_valid is raised. After reset deasserts, the block is in IDLE.

Test Plan:
1. Single op, ADD_CYCLES=1: req0 a=76543210 b=87654321 cin=0 → res0 sum=FDB97531 cout=0 ovf=0, res0_valid 2 cycles after the handshake edge; req1 side stays idle.
2. Carry wrap: req1 a=FFFFFFFF b=00000001 cin=0 → res1 sum=00000000 cout=1 ovf=0. Then a=FFFFFFFF b=FFFFFFFF → sum=FFFFFFFE cout=1 ovf=0. Then a=7FFFFFFF b=00000001 → sum=80000000 cout=0 ovf=1.
3. Round-robin: both valid continuously with results drained immediately → grants alternate 0,1,0,1 starting with 0 after reset. Each result matches its own operands (req0 a=1 b=2 → 3; req1 a=10 b=20 → 30).
4. Backpressure: res0_ready=0 with res0 full, both valid → only req1 is granted repeatedly and req0_ready stays 0. Raise res0_ready for one cycle → req0 is granted at the next IDLE.
5. ADD_CYCLES=4: handshake at edge E → add_a/b stay stable for 4 cycles, capture at E+4, and req*_ready=0 throughout EXEC.
6. Reset mid-EXEC (ADD_CYCLES=4, rst on the 2nd EXEC cycle) → all res_valid=0, add_a=0, state IDLE. The next request is served normally and req0 wins a tie.

Source files
------------

// File: rtl/cla32_arbiter.sv
// Round-robin arbiter that time-shares one external adder between two requesters,
// holding registered operands for ADD_CYCLES cycles and capturing into per-requester result slots.
module cla32_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res0_valid,
  input  logic             res0_ready,
  output logic [WIDTH-1:0] res0_sum,
  output logic             res0_cout,
  output logic             res0_ovf,
  output logic             res1_valid,
  input  logic             res1_ready,
  output logic [WIDTH-1:0] res1_sum,
  output logic             res1_cout,
  output logic             res1_ovf,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_ovf
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       last_grant;
  logic       eligible0;
  logic       eligible1;
  logic       grant_vld;
  logic       grant;

  // A requester with an unread result is held off so its slot is never overwritten.
  assign eligible0 = req0_valid && !res0_valid;
  assign eligible1 = req1_valid && !res1_valid;

  always_comb begin
    grant_vld = eligible0 || eligible1;
    grant     = 1'b0;
    if (eligible0 && eligible1) grant = !last_grant;
    else if (eligible1)         grant = 1'b1;
  end

  assign req0_ready = !rst && (state == IDLE) && grant_vld && !grant;
  assign req1_ready = !rst && (state == IDLE) && grant_vld && grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      res0_valid <= 1'b0;
      res0_sum   <= '0;
      res0_cout  <= 1'b0;
      res0_ovf   <= 1'b0;
      res1_valid <= 1'b0;
      res1_sum   <= '0;
      res1_cout  <= 1'b0;
      res1_ovf   <= 1'b0;
    end else begin
      if (res0_valid && res0_ready) res0_valid <= 1'b0;
      if (res1_valid && res1_ready) res1_valid <= 1'b0;
      case (state)
        IDLE: begin
          // grant_vld already implies the granted requester is valid
          if (grant_vld) begin
            state      <= EXEC;
            owner      <= grant;
            last_grant <= grant;
            cnt        <= 4'(ADD_CYCLES - 1);
            add_a      <= grant ? req1_a   : req0_a;
            add_b      <= grant ? req1_b   : req0_b;
            add_cin    <= grant ? req1_cin : req0_cin;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            if (owner) begin
              res1_valid <= 1'b1;
              res1_sum   <= add_sum;
              res1_cout  <= add_cout;
              res1_ovf   <= add_ovf;
            end else begin
              res0_valid <= 1'b1;
              res0_sum   <= add_sum;
              res0_cout  <= add_cout;
              res0_ovf   <= add_ovf;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla32_arbiter.sv
// Two arbiters (settle 1 and 4 cycles) driven by the same stimulus and checked
// every cycle against a transaction-level model of grants, latency and results.
module tb_cla32_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, v1 = 1'b0, c0 = 1'b0, c1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic        rdy0 [2], rdy1 [2], rv0 [2], rv1 [2];
  logic        co0 [2], co1 [2], ov0 [2], ov1 [2];
  logic        acin [2], acout [2], aovf [2];
  logic [31:0] s0 [2], s1 [2], aa [2], ab [2], asum [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : gi
      cla32_arbiter #(.WIDTH(32), .ADD_CYCLES(g == 0 ? 1 : 4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0[g]), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(rdy1[g]), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
        .res0_valid(rv0[g]), .res0_ready(rr0), .res0_sum(s0[g]), .res0_cout(co0[g]), .res0_ovf(ov0[g]),
        .res1_valid(rv1[g]), .res1_ready(rr1), .res1_sum(s1[g]), .res1_cout(co1[g]), .res1_ovf(ov1[g]),
        .add_a(aa[g]), .add_b(ab[g]), .add_cin(acin[g]),
        .add_sum(asum[g]), .add_cout(acout[g]), .add_ovf(aovf[g])
      );
      // stand-in for the shared cla32
      assign {acout[g], asum[g]} = {1'b0, aa[g]} + {1'b0, ab[g]} + {32'd0, acin[g]};
      assign aovf[g] = (aa[g][31] == ab[g][31]) && (asum[g][31] != aa[g][31]);
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: rem = edges left until capture (0 = idle), plus result slots.
  int        rem [2];
  bit        last [2];
  bit        own [2];
  bit [31:0] ma [2], mb [2];
  bit        mc [2];
  bit        mv [2][2];
  bit [31:0] ms [2][2];
  bit        mco [2][2], mov [2][2];

  function automatic int settle(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic bit model_ready(int k, int n);
    bit e0, e1;
    int w;
    e0 = v0 && !mv[k][0];
    e1 = v1 && !mv[k][1];
    if (rst || rem[k] != 0) return 1'b0;
    if (e0 && e1)  w = last[k] ? 0 : 1;
    else if (e0)   w = 0;
    else if (e1)   w = 1;
    else           return 1'b0;
    return w == n;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k] = 0; last[k] = 1'b1; own[k] = 1'b0;
        ma[k] = '0; mb[k] = '0; mc[k] = 1'b0;
        for (int n = 0; n < 2; n++) begin
          mv[k][n] = 1'b0; ms[k][n] = '0; mco[k][n] = 1'b0; mov[k][n] = 1'b0;
        end
      end else begin
        bit r0, r1;
        r0 = model_ready(k, 0);
        r1 = model_ready(k, 1);
        if (mv[k][0] && rr0) mv[k][0] = 1'b0;
        if (mv[k][1] && rr1) mv[k][1] = 1'b0;
        if (rem[k] != 0) begin
          rem[k]--;
          if (rem[k] == 0) begin
            longint ua, sa;
            ua = longint'(ma[k]) + longint'(mb[k]) + longint'(mc[k]);
            sa = longint'($signed(ma[k])) + longint'($signed(mb[k])) + longint'(mc[k]);
            ms[k][own[k]]  = ua[31:0];
            mco[k][own[k]] = ua >= 64'd4294967296;
            mov[k][own[k]] = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
            mv[k][own[k]]  = 1'b1;
          end
        end else if (r0) begin
          ma[k] = a0; mb[k] = b0; mc[k] = c0; own[k] = 1'b0; last[k] = 1'b0; rem[k] = settle(k);
        end else if (r1) begin
          ma[k] = a1; mb[k] = b1; mc[k] = c1; own[k] = 1'b1; last[k] = 1'b1; rem[k] = settle(k);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d.rdy0", k), rdy0[k], model_ready(k, 0));
      chk($sformatf("i%0d.rdy1", k), rdy1[k], model_ready(k, 1));
      chk($sformatf("i%0d.rv0", k),  rv0[k],  mv[k][0]);
      chk($sformatf("i%0d.rv1", k),  rv1[k],  mv[k][1]);
      chk($sformatf("i%0d.res0", k), {s0[k], co0[k], ov0[k]}, {ms[k][0], mco[k][0], mov[k][0]});
      chk($sformatf("i%0d.res1", k), {s1[k], co1[k], ov1[k]}, {ms[k][1], mco[k][1], mov[k][1]});
      chk($sformatf("i%0d.add", k),  {aa[k], ab[k], acin[k]}, {ma[k], mb[k], mc[k]});
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_op(input bit n, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic [31:0] es, input logic eco, input logic eov);
    if (n) begin v1 = 1'b1; a1 = a; b1 = b; c1 = c; end
    else   begin v0 = 1'b1; a0 = a; b0 = b; c0 = c; end
    cyc();
    v0 = 1'b0; v1 = 1'b0;
    repeat (6) cyc();
    for (int k = 0; k < 2; k++) begin
      if (n) chk($sformatf("op.i%0d.r1", k), {rv1[k], s1[k], co1[k], ov1[k]}, {1'b1, es, eco, eov});
      else   chk($sformatf("op.i%0d.r0", k), {rv0[k], s0[k], co0[k], ov0[k]}, {1'b1, es, eco, eov});
    end
    if (n) rr1 = 1'b1; else rr0 = 1'b1;
    cyc();
    rr0 = 1'b0; rr1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) chk($sformatf("rst.i%0d", k), {rv0[k], rv1[k], aa[k]}, 34'd0);

    do_op(1'b0, 32'h76543210, 32'h87654321, 1'b0, 32'hFDB97531, 1'b0, 1'b0);
    do_op(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    do_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
    do_op(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);

    // round robin with immediate drain
    v0 = 1'b1; v1 = 1'b1; a0 = 32'd1; b0 = 32'd2; a1 = 32'd10; b1 = 32'd20; c0 = 1'b0; c1 = 1'b0;
    rr0 = 1'b1; rr1 = 1'b1;
    repeat (24) cyc();

    // result-slot backpressure on requester 0
    rr0 = 1'b0;
    repeat (24) cyc();
    rr0 = 1'b1;
    cyc();
    rr0 = 1'b0;
    repeat (12) cyc();

    // reset during the second EXEC cycle of the slow instance
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    repeat (8) cyc();
    rr0 = 1'b0; rr1 = 1'b0;
    v0 = 1'b1; a0 = 32'h12345678; b0 = 32'h11111111;
    cyc();
    v0 = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstx.i1", {rv0[1], rv1[1], aa[1]}, 34'd0);
    v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("rstx.tie", {rdy0[1], rdy1[1]}, 2'b10);
    rr0 = 1'b1; rr1 = 1'b1;
    repeat (12) cyc();

    for (int i = 0; i < 3000; i++) begin
      v0  = ($urandom % 4) != 0;
      v1  = ($urandom % 4) != 0;
      rr0 = ($urandom % 3) != 0;
      rr1 = ($urandom % 3) != 0;
      a0  = ($urandom % 8 == 0) ? 32'hFFFFFFFF : $urandom;
      b0  = ($urandom % 8 == 0) ? 32'h7FFFFFFF : $urandom;
      a1  = $urandom;
      b1  = ($urandom % 8 == 0) ? 32'h80000000 : $urandom;
      c0  = 1'($urandom);
      c1  = 1'($urandom);
      rst = ($urandom % 150) == 0;
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
